// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the fetch stage: FSM encoding, NOP word,
// skid-buffer entry and word alignment helper.
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } skid_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-cache read port with busywait handshake.
// master = fetch unit, slave = cache.
interface instruction_fetch_unit_if;

   logic        imem_read;
   logic [31:0] imem_address;
   logic [31:0] imem_readdata;
   logic        imem_busywait;

   modport master (
      output imem_read,
      output imem_address,
      input  imem_readdata,
      input  imem_busywait
   );

   modport slave (
      input  imem_read,
      input  imem_address,
      output imem_readdata,
      output imem_busywait
   );

endinterface

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry {instr,pc} buffer catching a cache response
// that arrives while decode is stalled.
module fetch_skid_buffer
   import instruction_fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        clear,
   input  skid_entry_t din,
   output skid_entry_t dout,
   output logic        valid
);

   skid_entry_t ent_q, ent_d;
   logic        vld_q, vld_d;

   always_comb begin
      ent_d = ent_q;
      vld_d = vld_q;
      if (load) begin
         ent_d = din;
         vld_d = 1'b1;
      end else if (clear) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q <= '0;
         vld_q <= 1'b0;
      end else begin
         ent_q <= ent_d;
         vld_q <= vld_d;
      end
   end

   assign dout  = ent_q;
   assign valid = vld_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the I-cache, squashes
// wrong-path fetches on redirect and drives the IF/ID register.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      branch_or_jump_signal,
   input  logic [31:0]               branch_jump_addres,
   input  logic                      STALL,
   instruction_fetch_unit_if.master  imem,
   output logic [31:0]               INSTRUCTION,
   output logic [31:0]               PC,
   output logic [31:0]               INCREMENTED_PC_by_four,
   output logic                      VALID
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         pend_q, pend_d;
   logic [31:0]  tgt_q, tgt_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pco_q, pco_d;
   logic [31:0]  pc4_q, pc4_d;
   logic         valid_q, valid_d;

   logic         done;
   logic         redir;
   logic [31:0]  target;
   logic         skid_load;
   logic         skid_clear;
   logic         skid_vld;
   skid_entry_t  skid_in;
   skid_entry_t  skid_out;

   assign redir  = branch_or_jump_signal;
   assign target = align_word(branch_jump_addres);
   assign done   = (state_q == S_FETCH) && !imem.imem_busywait;

   assign skid_in = '{instr: imem.imem_readdata, pc: pc_q};

   fetch_skid_buffer u_skid (
      .clk   (CLK),
      .rst_n (RESET),
      .load  (skid_load),
      .clear (skid_clear),
      .din   (skid_in),
      .dout  (skid_out),
      .valid (skid_vld)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      tgt_d      = tgt_q;
      instr_d    = instr_q;
      pco_d      = pco_q;
      pc4_d      = pc4_q;
      valid_d    = valid_q;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (redir && !done) begin
               // in-flight read must finish before the target is fetched
               pend_d  = 1'b1;
               tgt_d   = target;
               valid_d = 1'b0;
            end else if (done && (redir || pend_q)) begin
               pc_d    = redir ? target : tgt_q;
               pend_d  = 1'b0;
               valid_d = 1'b0;
            end else if (done && STALL) begin
               skid_load = 1'b1;
               state_d   = S_HOLD;
            end else if (done) begin
               instr_d = imem.imem_readdata;
               pco_d   = pc_q;
               pc4_d   = pc_q + 32'd4;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
            end else if (!STALL) begin
               valid_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (redir) begin
               skid_clear = 1'b1;
               pc_d       = target;
               valid_d    = 1'b0;
               state_d    = S_FETCH;
            end else if (!STALL && skid_vld) begin
               skid_clear = 1'b1;
               instr_d    = skid_out.instr;
               pco_d      = skid_out.pc;
               pc4_d      = skid_out.pc + 32'd4;
               valid_d    = 1'b1;
               pc_d       = skid_out.pc + 32'd4;
               state_d    = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         pend_q  <= 1'b0;
         tgt_q   <= '0;
         instr_q <= NOP_INSTR;
         pco_q   <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         tgt_q   <= tgt_d;
         instr_q <= instr_d;
         pco_q   <= pco_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign imem.imem_read    = (state_q == S_FETCH);
   assign imem.imem_address = pc_q;

   assign INSTRUCTION            = valid_q ? instr_q : NOP_INSTR;
   assign PC                     = pco_q;
   assign INCREMENTED_PC_by_four = pc4_q;
   assign VALID                  = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch stage; the cache returns
// address ^ 32'hCAFE_0000 and busywait is driven per cycle.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        redir;
   logic [31:0] tgt;
   logic        stall;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        valid;

   int n_checks;
   int n_errors;

   instruction_fetch_unit_if bus ();

   assign bus.imem_readdata = bus.imem_address ^ 32'hCAFE_0000;

   instruction_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .CLK                    (clk),
      .RESET                  (rst_n),
      .branch_or_jump_signal  (redir),
      .branch_jump_addres     (tgt),
      .STALL                  (stall),
      .imem                   (bus.master),
      .INSTRUCTION            (instr),
      .PC                     (pc),
      .INCREMENTED_PC_by_four (pc4),
      .VALID                  (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag,
                          input logic v,
                          input logic [31:0] p,
                          input logic [31:0] p4,
                          input logic [31:0] ins);
      check({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
      check({tag, ".pc"}, pc, p);
      check({tag, ".pc4"}, pc4, p4);
      check({tag, ".instr"}, instr, ins);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      redir = 1'b0;
      tgt   = '0;
      stall = 1'b0;
      bus.imem_busywait = 1'b0;
      repeat (2) @(negedge clk);

      // reset state
      chk_out("rst", 1'b0, 32'h0, 32'h0, 32'h13);
      check("rst.read", {31'd0, bus.imem_read}, 32'd0);
      rst_n = 1'b1;

      // 1: sequential 0-wait fetch
      step();
      check("t1.read", {31'd0, bus.imem_read}, 32'd1);
      check("t1.addr", bus.imem_address, 32'h0);
      check("t1.valid0", {31'd0, valid}, 32'd0);
      step();
      chk_out("t1.a", 1'b1, 32'h0, 32'h4, 32'hCAFE_0000);
      step();
      chk_out("t1.b", 1'b1, 32'h4, 32'h8, 32'hCAFE_0004);
      step();
      chk_out("t1.c", 1'b1, 32'h8, 32'hC, 32'hCAFE_0008);
      step();
      check("t1.d.pc", pc, 32'hC);
      check("t1.d.addr", bus.imem_address, 32'h10);

      // 2: three busy cycles on 0x10
      bus.imem_busywait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2.valid", {31'd0, valid}, 32'd0);
         check("t2.addr", bus.imem_address, 32'h10);
         check("t2.read", {31'd0, bus.imem_read}, 32'd1);
      end
      bus.imem_busywait = 1'b0;
      step();
      chk_out("t2.ret", 1'b1, 32'h10, 32'h14, 32'hCAFE_0010);

      // 3: redirect while 0x20 is busy
      repeat (3) step();
      check("t3.addr20", bus.imem_address, 32'h20);
      bus.imem_busywait = 1'b1;
      redir = 1'b1;
      tgt   = 32'h0000_0201;
      step();
      redir = 1'b0;
      check("t3.v0", {31'd0, valid}, 32'd0);
      check("t3.addr_hold", bus.imem_address, 32'h20);
      step();
      check("t3.v1", {31'd0, valid}, 32'd0);
      bus.imem_busywait = 1'b0;
      step();
      check("t3.v2", {31'd0, valid}, 32'd0);
      check("t3.newaddr", bus.imem_address, 32'h200);
      step();
      chk_out("t3.tgt", 1'b1, 32'h200, 32'h204, 32'hCAFE_0200);

      // 4: stall two cycles as 0x30 returns
      redir = 1'b1;
      tgt   = 32'h30;
      step();
      redir = 1'b0;
      check("t4.addr", bus.imem_address, 32'h30);
      stall = 1'b1;
      step();
      check("t4.hold.read", {31'd0, bus.imem_read}, 32'd0);
      check("t4.hold.valid", {31'd0, valid}, 32'd0);
      check("t4.hold.pc", pc, 32'h200);
      step();
      check("t4.hold2.read", {31'd0, bus.imem_read}, 32'd0);
      check("t4.hold2.pc", pc, 32'h200);
      stall = 1'b0;
      step();
      chk_out("t4.skid", 1'b1, 32'h30, 32'h34, 32'hCAFE_0030);
      step();
      chk_out("t4.next", 1'b1, 32'h34, 32'h38, 32'hCAFE_0034);

      // 5: redirect and stall together in HOLD
      stall = 1'b1;
      step();
      chk_out("t5.frozen", 1'b1, 32'h34, 32'h38, 32'hCAFE_0034);
      check("t5.read", {31'd0, bus.imem_read}, 32'd0);
      redir = 1'b1;
      tgt   = 32'h400;
      step();
      redir = 1'b0;
      stall = 1'b0;
      check("t5.valid", {31'd0, valid}, 32'd0);
      check("t5.read1", {31'd0, bus.imem_read}, 32'd1);
      check("t5.addr", bus.imem_address, 32'h400);
      step();
      chk_out("t5.tgt", 1'b1, 32'h400, 32'h404, 32'hCAFE_0400);

      // 6: PC wrap, then async reset mid-read
      redir = 1'b1;
      tgt   = 32'hFFFF_FFFC;
      step();
      redir = 1'b0;
      step();
      chk_out("t6.wrap", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h3501_FFFC);
      check("t6.addr", bus.imem_address, 32'h0);
      bus.imem_busywait = 1'b1;
      step();
      check("t6.busy.read", {31'd0, bus.imem_read}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("t6.arst", 1'b0, 32'h0, 32'h0, 32'h13);
      check("t6.arst.read", {31'd0, bus.imem_read}, 32'd0);
      check("t6.arst.addr", bus.imem_address, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.imem_busywait = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
